wash_sequencer: RTL and testbench
=================================

Name: wash_sequencer

Overview:
- Parametrised successor to the single-rinse washing-machine FSM.
- Sequences door lock, fill, detergent, wash, drain, N rinse passes, and spin.
- Wash/spin durations are timed internally; fill/drain have watchdogs; the door is supervised; pause is supported.
- Sits between the panel/sensor inputs and the valve/motor drivers; all outputs are registered.

Parameters:
- TIMER_W, 16, width of the shared phase timer.
- WASH_TICKS, 1000, clk cycles of agitation per wash/rinse pass (≥1, < 2^TIMER_W).
- SPIN_TICKS, 500, clk cycles of spin (≥1).
- RINSE_CNT, 2, rinse passes after the soap wash (0..15).
- FILL_TIMEOUT, 2000, max cycles in FILL before fault.
- DRAIN_TIMEOUT, 2000, max cycles in DRAIN before fault.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  begin program (sampled in IDLE only)
- door_close  in  1  door-closed sensor
- filled  in  1  level sensor, drum full
- detergent_added  in  1  detergent dispensed
- drained  in  1  drum empty
- pause  in  1  hold agitation/spin
- door_lock  out  1  door latch
- motor_on  out  1  drum motor
- fill_valve_on  out  1  inlet valve
- drain_valve_on  out  1  drain pump
- soap_wash  out  1  high during soap-pass FILL/DETERGENT/WASH/DRAIN
- rinse_count  out  4  completed rinse passes
- done  out  1  one-cycle completion pulse
- fault  out  1  sticky fault flag

Behaviour:
- Reset: reset==0 at a clk edge forces IDLE, clears the timer and rinse_count, and sets every output to 0. This applies mid-operation too, including from FAULT.
- Outputs: decoded from next_state and registered with the state, so there is no combinational input→output path. Outputs follow a state change in the same edge.
- Timer: cleared on every state entry, then incremented each cycle. In WASH/SPIN it holds while pause==1.
- IDLE: all outputs 0. start&&door_close → FILL with soap phase, rinse_count=0.
- FILL: fill_valve_on=1, door_lock=1.
  - filled → DETERGENT if soap phase, else WASH.
  - timer==FILL_TIMEOUT-1 without filled → FAULT.
- DETERGENT: door_lock=1. detergent_added → WASH. No watchdog.
- WASH: motor_on=!pause, door_lock=1.
  - Leaves for DRAIN when timer==WASH_TICKS-1 && !pause, i.e. exactly WASH_TICKS unpaused cycles.
  - pause freezes the timer and motor only; the state is kept.
- DRAIN: drain_valve_on=1, door_lock=1.
  - On drained:
    - soap phase → clear the soap phase; FILL if RINSE_CNT>0, else SPIN.
    - rinse phase → rinse_count+1; FILL if the new count < RINSE_CNT, else SPIN.
  - timer==DRAIN_TIMEOUT-1 without drained → FAULT.
- SPIN: motor_on=!pause, drain_valve_on=1, door_lock=1. Exits to DONE after SPIN_TICKS unpaused cycles.
- DONE: lasts one cycle. done=1, door_lock=0, rinse_count holds its final value. → IDLE; rinse_count clears on the next start.
- FAULT: fault=1, drain_valve_on=1, door_lock=1, motor and fill off. Exits only via reset.
- Door supervision: door_close==0 in any state other than IDLE/DONE/FAULT → FAULT next edge. This takes priority over all other transitions.
- Simultaneous events:
  - Sensor and watchdog expiry in the same cycle: the sensor wins.
  - pause in FILL/DRAIN/DETERGENT is ignored.
  - start outside IDLE is ignored.
- Illegal state encoding → IDLE.

Decomposition:
- Package washer_pkg: state enum (IDLE, FILL, DETERGENT, WASH, DRAIN, SPIN, DONE, FAULT; 3-bit) and the RINSE_W=4 constant.
- Sub-module phase_timer (TIMER_W): sync clear, hold enable, count output, compare-to-limit terminal flag.
- One phase_timer instance is shared across all timed states.

Test Plan (WASH_TICKS=4, SPIN_TICKS=3, RINSE_CNT=1, FILL/DRAIN_TIMEOUT=8):
- Full run, sensors asserted 2 cycles after each state entry:
  - Sequence is IDLE→FILL→DETERGENT→WASH→DRAIN→FILL→WASH→DRAIN→SPIN→DONE→IDLE.
  - motor_on high exactly 4 cycles per wash and 3 in spin.
  - rinse_count==1 at DONE; done high for 1 cycle.
- Pause: pause=1 for 5 cycles mid-WASH → motor_on=0 and the timer frozen during pause; WASH total = 9 cycles.
- Fill watchdog: never assert filled → FAULT after 8 cycles in FILL, fault=1, drain_valve_on=1. start is ignored until reset=0.
- Door open: drop door_close during SPIN → FAULT next edge, motor_on=0, door_lock=1.
- Reset mid-operation: reset=0 for 1 cycle during WASH → all outputs 0, IDLE, rinse_count=0.
- Sensor versus watchdog collision: drained asserted on the same cycle the timer reaches 7 in DRAIN → transitions normally, with no fault.

Source files
------------

// File: rtl/wash_sequencer_pkg.sv
// Shared types for the wash sequencer: state encoding, rinse counter width
// and state-group helpers.
package washer_pkg;

  localparam int RINSE_W = 4;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_DETERGENT = 3'd2,
    S_WASH      = 3'd3,
    S_DRAIN     = 3'd4,
    S_SPIN      = 3'd5,
    S_DONE      = 3'd6,
    S_FAULT     = 3'd7
  } state_t;

  // States in which an open door is a fault condition.
  function automatic logic is_supervised(state_t s);
    return s inside {S_FILL, S_DETERGENT, S_WASH, S_DRAIN, S_SPIN};
  endfunction

  // States that count as part of the soap pass when the soap phase is active.
  function automatic logic is_pass_state(state_t s);
    return s inside {S_FILL, S_DETERGENT, S_WASH, S_DRAIN};
  endfunction

endpackage

// File: rtl/wash_sequencer_if.sv
// Panel/sensor inputs and valve/motor driver outputs of the wash sequencer.
interface wash_sequencer_if;
  import washer_pkg::*;

  logic               start;
  logic               door_close;
  logic               filled;
  logic               detergent_added;
  logic               drained;
  logic               pause;
  logic               door_lock;
  logic               motor_on;
  logic               fill_valve_on;
  logic               drain_valve_on;
  logic               soap_wash;
  logic [RINSE_W-1:0] rinse_count;
  logic               done;
  logic               fault;

  modport master (
    output start, door_close, filled, detergent_added, drained, pause,
    input  door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
           rinse_count, done, fault
  );

  modport slave (
    input  start, door_close, filled, detergent_added, drained, pause,
    output door_lock, motor_on, fill_valve_on, drain_valve_on, soap_wash,
           rinse_count, done, fault
  );

endinterface

// File: rtl/wash_sequencer_phase_timer.sv
// Phase timer shared by all timed states: sync clear, hold, and a terminal
// flag when the count equals the supplied limit.
module phase_timer #(
  parameter int TIMER_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr_i,
  input  logic               hold_i,
  input  logic [TIMER_W-1:0] limit_i,
  output logic [TIMER_W-1:0] count_o,
  output logic               tc_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (!hold_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == limit_i);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine program sequencer: fill, detergent, wash, drain, N rinses,
// spin. Outputs are decoded from the next state and registered with it.
module wash_sequencer
  import washer_pkg::*;
#(
  parameter int TIMER_W       = 16,
  parameter int WASH_TICKS    = 1000,
  parameter int SPIN_TICKS    = 500,
  parameter int RINSE_CNT     = 2,
  parameter int FILL_TIMEOUT  = 2000,
  parameter int DRAIN_TIMEOUT = 2000
) (
  input  logic            clk,
  input  logic            reset,
  wash_sequencer_if.slave bus
);

  localparam logic [TIMER_W-1:0] FILL_LIM  = TIMER_W'(FILL_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] DRAIN_LIM = TIMER_W'(DRAIN_TIMEOUT - 1);
  localparam logic [TIMER_W-1:0] WASH_LIM  = TIMER_W'(WASH_TICKS - 1);
  localparam logic [TIMER_W-1:0] SPIN_LIM  = TIMER_W'(SPIN_TICKS - 1);

  state_t             state_q, state_d;
  logic               soap_q, soap_d;
  logic [RINSE_W-1:0] rinse_q, rinse_d, rinse_inc;

  logic door_lock_q, door_lock_d;
  logic motor_q, motor_d;
  logic fill_q, fill_d;
  logic drain_q, drain_d;
  logic soap_out_q, soap_out_d;
  logic done_q, done_d;
  logic fault_q, fault_d;

  logic               timer_clr, timer_hold, timer_tc;
  logic [TIMER_W-1:0] timer_lim, timer_cnt;

  always_comb begin
    timer_lim = WASH_LIM;
    case (state_q)
      S_FILL:  timer_lim = FILL_LIM;
      S_DRAIN: timer_lim = DRAIN_LIM;
      S_SPIN:  timer_lim = SPIN_LIM;
      default: timer_lim = WASH_LIM;
    endcase
  end

  // Any state change restarts the timer; pause only freezes agitation/spin.
  assign timer_clr  = (state_d != state_q);
  assign timer_hold = bus.pause && (state_q == S_WASH || state_q == S_SPIN);

  phase_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clr_i   (timer_clr),
    .hold_i  (timer_hold),
    .limit_i (timer_lim),
    .count_o (timer_cnt),
    .tc_o    (timer_tc)
  );

  assign rinse_inc = rinse_q + RINSE_W'(1);

  always_comb begin
    state_d = state_q;
    soap_d  = soap_q;
    rinse_d = rinse_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.door_close) begin
          state_d = S_FILL;
          soap_d  = 1'b1;
          rinse_d = '0;
        end
      end
      S_FILL: begin
        if (bus.filled)    state_d = soap_q ? S_DETERGENT : S_WASH;
        else if (timer_tc) state_d = S_FAULT;
      end
      S_DETERGENT: begin
        if (bus.detergent_added) state_d = S_WASH;
      end
      S_WASH: begin
        if (timer_tc && !bus.pause) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (bus.drained) begin
          if (soap_q) begin
            soap_d  = 1'b0;
            state_d = (RINSE_CNT > 0) ? S_FILL : S_SPIN;
          end else begin
            rinse_d = rinse_inc;
            state_d = (int'(rinse_inc) < RINSE_CNT) ? S_FILL : S_SPIN;
          end
        end else if (timer_tc) begin
          state_d = S_FAULT;
        end
      end
      S_SPIN: begin
        if (timer_tc && !bus.pause) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    // An open door overrides everything else while the drum is in use.
    if (is_supervised(state_q) && !bus.door_close) begin
      state_d = S_FAULT;
      soap_d  = soap_q;
      rinse_d = rinse_q;
    end

    door_lock_d = is_supervised(state_d) || (state_d == S_FAULT);
    motor_d     = (state_d == S_WASH || state_d == S_SPIN) && !bus.pause;
    fill_d      = (state_d == S_FILL);
    drain_d     = (state_d == S_DRAIN || state_d == S_SPIN || state_d == S_FAULT);
    soap_out_d  = soap_d && is_pass_state(state_d);
    done_d      = (state_d == S_DONE);
    fault_d     = (state_d == S_FAULT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      soap_q      <= 1'b0;
      rinse_q     <= '0;
      door_lock_q <= 1'b0;
      motor_q     <= 1'b0;
      fill_q      <= 1'b0;
      drain_q     <= 1'b0;
      soap_out_q  <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      soap_q      <= soap_d;
      rinse_q     <= rinse_d;
      door_lock_q <= door_lock_d;
      motor_q     <= motor_d;
      fill_q      <= fill_d;
      drain_q     <= drain_d;
      soap_out_q  <= soap_out_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.door_lock      = door_lock_q;
  assign bus.motor_on       = motor_q;
  assign bus.fill_valve_on  = fill_q;
  assign bus.drain_valve_on = drain_q;
  assign bus.soap_wash      = soap_out_q;
  assign bus.rinse_count    = rinse_q;
  assign bus.done           = done_q;
  assign bus.fault          = fault_q;

  a_wash_timer_bound: assert property (@(posedge clk) disable iff (!reset)
    (state_q == S_WASH) |-> (timer_cnt < TIMER_W'(WASH_TICKS)));

endmodule

// File: tb/tb_wash_sequencer.sv
// Self-checking bench for wash_sequencer: directed scenarios plus a random
// soak, all compared against a cycle-level model of the program rules.
module tb_wash_sequencer;
  import washer_pkg::*;

  localparam int WASH_T   = 4;
  localparam int SPIN_T   = 3;
  localparam int RINSE_N  = 1;
  localparam int FILL_TO  = 8;
  localparam int DRAIN_TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  wash_sequencer_if wif ();

  wash_sequencer #(
    .TIMER_W       (16),
    .WASH_TICKS    (WASH_T),
    .SPIN_TICKS    (SPIN_T),
    .RINSE_CNT     (RINSE_N),
    .FILL_TIMEOUT  (FILL_TO),
    .DRAIN_TIMEOUT (DRAIN_TO)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (wif)
  );

  // Reference model: program phase, unpaused time in phase, cycles in phase.
  state_t m_ph = S_IDLE;
  int     m_t = 0;
  int     m_age = 0;
  bit     m_soap = 0;
  int     m_rc = 0;
  bit     m_lastpause = 0;
  int     cur_dly = 0;

  function automatic logic [10:0] obs_vec();
    return {wif.door_lock, wif.motor_on, wif.fill_valve_on, wif.drain_valve_on,
            wif.soap_wash, wif.rinse_count, wif.done, wif.fault};
  endfunction

  function automatic logic [10:0] exp_vec();
    logic lock, mot, fil, drn, sp, dn, flt;
    lock = (m_ph != S_IDLE) && (m_ph != S_DONE);
    mot  = (m_ph == S_WASH || m_ph == S_SPIN) && !m_lastpause;
    fil  = (m_ph == S_FILL);
    drn  = (m_ph == S_DRAIN || m_ph == S_SPIN || m_ph == S_FAULT);
    sp   = m_soap && (m_ph == S_FILL || m_ph == S_DETERGENT || m_ph == S_WASH || m_ph == S_DRAIN);
    dn   = (m_ph == S_DONE);
    flt  = (m_ph == S_FAULT);
    return {lock, mot, fil, drn, sp, 4'(m_rc), dn, flt};
  endfunction

  task automatic model_step();
    state_t nxt;
    bit in_use;
    if (!rst_n) begin
      m_ph = S_IDLE; m_t = 0; m_age = 0; m_soap = 0; m_rc = 0; m_lastpause = 0;
      return;
    end
    nxt = m_ph;
    in_use = (m_ph == S_FILL || m_ph == S_DETERGENT || m_ph == S_WASH ||
              m_ph == S_DRAIN || m_ph == S_SPIN);
    if (in_use && !wif.door_close) begin
      nxt = S_FAULT;
    end else begin
      case (m_ph)
        S_IDLE: if (wif.start && wif.door_close) begin
          nxt = S_FILL; m_soap = 1; m_rc = 0;
        end
        S_FILL: begin
          if (wif.filled) nxt = m_soap ? S_DETERGENT : S_WASH;
          else if (m_t == FILL_TO - 1) nxt = S_FAULT;
        end
        S_DETERGENT: if (wif.detergent_added) nxt = S_WASH;
        S_WASH: if (!wif.pause && m_t == WASH_T - 1) nxt = S_DRAIN;
        S_DRAIN: begin
          if (wif.drained) begin
            if (m_soap) begin
              m_soap = 0;
              nxt = (RINSE_N > 0) ? S_FILL : S_SPIN;
            end else begin
              m_rc = m_rc + 1;
              nxt = (m_rc < RINSE_N) ? S_FILL : S_SPIN;
            end
          end else if (m_t == DRAIN_TO - 1) begin
            nxt = S_FAULT;
          end
        end
        S_SPIN: if (!wif.pause && m_t == SPIN_T - 1) nxt = S_DONE;
        S_DONE: nxt = S_IDLE;
        default: nxt = m_ph;
      endcase
    end
    if (nxt != m_ph) begin
      m_t = 0; m_age = 0;
    end else begin
      m_age++;
      if (!((m_ph == S_WASH || m_ph == S_SPIN) && wif.pause)) m_t++;
    end
    m_lastpause = wif.pause;
    m_ph = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // Sensors answer cur_dly cycles after the phase is entered.
  task automatic set_inputs(input int lo, input int hi, input int dlo, input int dhi,
                            input bit rnd_pause);
    if (m_age == 0)
      cur_dly = (m_ph == S_DRAIN) ? int'($urandom_range(dhi, dlo)) : int'($urandom_range(hi, lo));
    wif.start           = 1'b0;
    wif.door_close      = 1'b1;
    wif.filled          = (m_ph == S_FILL) && (m_age >= cur_dly);
    wif.detergent_added = (m_ph == S_DETERGENT) && (m_age >= cur_dly);
    wif.drained         = (m_ph == S_DRAIN) && (m_age >= cur_dly);
    wif.pause           = rnd_pause ? ($urandom_range(0, 2) == 0) : 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    set_inputs(0, 0, 0, 0, 0);
    tick();
    tick();
    tests++;
    if (obs_vec() !== 11'b0) begin
      fails++;
      $display("FAIL reset_outputs: got %b, expected %b", obs_vec(), 11'b0);
    end
    tests++;
    if (dut.state_q !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d, expected %0d", dut.state_q, S_IDLE);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_release: got %b, expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_full_run();
    state_t seq[$];
    int     bursts[$];
    state_t exp_seq[11] = '{S_IDLE, S_FILL, S_DETERGENT, S_WASH, S_DRAIN, S_FILL,
                            S_WASH, S_DRAIN, S_SPIN, S_DONE, S_IDLE};
    int     exp_bursts[3] = '{WASH_T, WASH_T, SPIN_T};
    int     run = 0, done_cnt = 0, rc_at_done = -1;
    bit     fin = 0;
    seq.push_back(dut.state_q);
    set_inputs(2, 2, 2, 2, 0);
    wif.start = 1'b1;
    tick();
    for (int c = 0; c < 200 && !fin; c++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL full_run outputs: got %b, expected %b", obs_vec(), exp_vec());
      end
      tests++;
      if (dut.state_q !== m_ph) begin
        fails++;
        $display("FAIL full_run state: got %0d, expected %0d", dut.state_q, m_ph);
      end
      if (dut.state_q != seq[$]) seq.push_back(dut.state_q);
      if (wif.motor_on) run++;
      else if (run > 0) begin bursts.push_back(run); run = 0; end
      if (wif.done) begin done_cnt++; rc_at_done = int'(wif.rinse_count); end
      if (done_cnt > 0 && dut.state_q == S_IDLE) fin = 1;
      else begin set_inputs(2, 2, 2, 2, 0); tick(); end
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL full_run timeout: got no return to IDLE, expected one"); end
    tests++;
    if (seq.size() != 11) begin
      fails++;
      $display("FAIL full_run seq_len: got %0d, expected 11", seq.size());
    end
    for (int i = 0; i < 11 && i < seq.size(); i++) begin
      tests++;
      if (seq[i] !== exp_seq[i]) begin
        fails++;
        $display("FAIL full_run seq[%0d]: got %0d, expected %0d", i, seq[i], exp_seq[i]);
      end
    end
    tests++;
    if (bursts.size() != 3) begin
      fails++;
      $display("FAIL full_run motor_bursts: got %0d bursts, expected 3", bursts.size());
    end
    for (int i = 0; i < 3 && i < bursts.size(); i++) begin
      tests++;
      if (bursts[i] != exp_bursts[i]) begin
        fails++;
        $display("FAIL full_run motor_len[%0d]: got %0d, expected %0d", i, bursts[i], exp_bursts[i]);
      end
    end
    tests++;
    if (done_cnt != 1) begin fails++; $display("FAIL full_run done_width: got %0d, expected 1", done_cnt); end
    tests++;
    if (rc_at_done != RINSE_N) begin
      fails++;
      $display("FAIL full_run rinse_at_done: got %0d, expected %0d", rc_at_done, RINSE_N);
    end
    tests++;
    if (wif.rinse_count !== 4'(RINSE_N)) begin
      fails++;
      $display("FAIL full_run rinse_in_idle: got %0d, expected %0d", wif.rinse_count, RINSE_N);
    end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    set_inputs(2, 2, 2, 2, 0);
    wif.start = 1'b1;
    tick();
    tests++;
    if (wif.rinse_count !== 4'd0 || wif.fill_valve_on !== 1'b1) begin
      fails++;
      $display("FAIL start_clears_rinse: got rc=%0d fill=%b, expected rc=0 fill=1", wif.rinse_count, wif.fill_valve_on);
    end
    for (int c = 0; c < 60 && !hit; c++) begin
      if (m_ph == S_WASH && m_age == 1) hit = 1;
      else begin set_inputs(2, 2, 2, 2, 0); tick(); end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL reset_mid timeout: got no WASH, expected WASH"); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if (obs_vec() !== 11'b0 || dut.state_q !== S_IDLE) begin
      fails++;
      $display("FAIL reset_mid: got out=%b state=%0d, expected out=0 state=%0d", obs_vec(), dut.state_q, S_IDLE);
    end
    set_inputs(2, 2, 2, 2, 0);
    tick();
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL reset_mid idle: got %b, expected %b", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_pause();
    int  wash_len[$];
    int  wash_mot[$];
    int  wl = 0, wm = 0, done_cnt = 0;
    bit  fin = 0;
    set_inputs(2, 2, 2, 2, 0);
    wif.start = 1'b1;
    tick();
    for (int c = 0; c < 200 && !fin; c++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL pause outputs: got %b, expected %b", obs_vec(), exp_vec());
      end
      if (m_ph == S_WASH && m_soap && m_age >= 3 && m_age <= 7) begin
        tests++;
        if (dut.timer_cnt !== 16'd2) begin
          fails++;
          $display("FAIL pause timer_frozen: got %0d, expected 2", dut.timer_cnt);
        end
      end
      if (dut.state_q == S_WASH) begin
        wl++;
        if (wif.motor_on) wm++;
      end else if (wl > 0) begin
        wash_len.push_back(wl); wash_mot.push_back(wm); wl = 0; wm = 0;
      end
      if (wif.done) done_cnt++;
      if (done_cnt > 0 && dut.state_q == S_IDLE) fin = 1;
      else begin
        set_inputs(2, 2, 2, 2, 0);
        if (m_ph == S_WASH && m_soap && m_age >= 2 && m_age <= 6) wif.pause = 1'b1;
        tick();
      end
    end
    tests++;
    if (!fin) begin fails++; $display("FAIL pause timeout: got no return to IDLE, expected one"); end
    tests++;
    if (wash_len.size() != 2 || wash_len[0] != 9 || wash_len[1] != WASH_T) begin
      fails++;
      $display("FAIL pause wash_len: got %p, expected '{9, %0d}", wash_len, WASH_T);
    end
    tests++;
    if (wash_mot.size() != 2 || wash_mot[0] != WASH_T || wash_mot[1] != WASH_T) begin
      fails++;
      $display("FAIL pause wash_motor: got %p, expected '{%0d, %0d}", wash_mot, WASH_T, WASH_T);
    end
  endtask

  task automatic test_collision();
    int  drain_len[$];
    int  dl = 0, done_cnt = 0, fault_cnt = 0;
    bit  fin = 0;
    set_inputs(7, 7, 7, 7, 0);
    wif.start = 1'b1;
    tick();
    for (int c = 0; c < 300 && !fin; c++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL collision outputs: got %b, expected %b", obs_vec(), exp_vec());
      end
      if (wif.fault) fault_cnt++;
      if (dut.state_q == S_DRAIN) dl++;
      else if (dl > 0) begin drain_len.push_back(dl); dl = 0; end
      if (wif.done) done_cnt++;
      if (done_cnt > 0 && dut.state_q == S_IDLE) fin = 1;
      else if (fault_cnt > 0) fin = 1;
      else begin set_inputs(7, 7, 7, 7, 0); tick(); end
    end
    tests++;
    if (fault_cnt != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL collision result: got fault=%0d done=%0d, expected fault=0 done=1", fault_cnt, done_cnt);
    end
    tests++;
    if (drain_len.size() != 2 || drain_len[0] != DRAIN_TO || drain_len[1] != DRAIN_TO) begin
      fails++;
      $display("FAIL collision drain_len: got %p, expected '{%0d, %0d}", drain_len, DRAIN_TO, DRAIN_TO);
    end
  endtask

  task automatic test_fill_watchdog();
    int fill_cycles = 0;
    bit hit = 0;
    set_inputs(1000, 1000, 1000, 1000, 0);
    wif.start = 1'b1;
    tick();
    for (int c = 0; c < 40 && !hit; c++) begin
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL watchdog outputs: got %b, expected %b", obs_vec(), exp_vec());
      end
      if (dut.state_q == S_FILL) fill_cycles++;
      if (dut.state_q == S_FAULT) hit = 1;
      else begin set_inputs(1000, 1000, 1000, 1000, 0); tick(); end
    end
    tests++;
    if (!hit || fill_cycles != FILL_TO) begin
      fails++;
      $display("FAIL watchdog fill_cycles: got %0d (fault=%b), expected %0d", fill_cycles, hit, FILL_TO);
    end
    tests++;
    if ({wif.door_lock, wif.motor_on, wif.fill_valve_on, wif.drain_valve_on, wif.fault} !== 5'b10011) begin
      fails++;
      $display("FAIL watchdog fault_outputs: got %b, expected 10011",
               {wif.door_lock, wif.motor_on, wif.fill_valve_on, wif.drain_valve_on, wif.fault});
    end
    for (int i = 0; i < 3; i++) begin
      set_inputs(0, 0, 0, 0, 0);
      wif.start = 1'b1;
      tick();
      tests++;
      if (dut.state_q !== S_FAULT || wif.fault !== 1'b1) begin
        fails++;
        $display("FAIL watchdog sticky: got state=%0d fault=%b, expected state=%0d fault=1", dut.state_q, wif.fault, S_FAULT);
      end
    end
    set_inputs(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if (obs_vec() !== 11'b0 || dut.state_q !== S_IDLE) begin
      fails++;
      $display("FAIL watchdog reset_exit: got out=%b state=%0d, expected out=0 state=%0d", obs_vec(), dut.state_q, S_IDLE);
    end
  endtask

  task automatic test_door_open();
    bit hit = 0;
    set_inputs(2, 2, 2, 2, 0);
    wif.start = 1'b1;
    tick();
    for (int c = 0; c < 100 && !hit; c++) begin
      if (m_ph == S_SPIN && m_age == 1) hit = 1;
      else begin set_inputs(2, 2, 2, 2, 0); tick(); end
    end
    tests++;
    if (!hit) begin fails++; $display("FAIL door timeout: got no SPIN, expected SPIN"); end
    set_inputs(2, 2, 2, 2, 0);
    wif.door_close = 1'b0;
    tick();
    tests++;
    if (dut.state_q !== S_FAULT || wif.fault !== 1'b1 || wif.motor_on !== 1'b0 || wif.door_lock !== 1'b1) begin
      fails++;
      $display("FAIL door_open: got state=%0d fault=%b motor=%b lock=%b, expected state=%0d fault=1 motor=0 lock=1",
               dut.state_q, wif.fault, wif.motor_on, wif.door_lock, S_FAULT);
    end
    tests++;
    if (obs_vec() !== exp_vec()) begin
      fails++;
      $display("FAIL door_open outputs: got %b, expected %b", obs_vec(), exp_vec());
    end
    set_inputs(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    int done_cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      set_inputs(0, 9, 0, 9, 1);
      if (m_ph == S_IDLE) begin
        wif.start      = ($urandom_range(0, 3) == 0);
        wif.door_close = ($urandom_range(0, 9) != 0);
      end else begin
        wif.start = ($urandom_range(0, 7) == 0);
        if (m_ph != S_FAULT && m_ph != S_DONE) wif.door_close = ($urandom_range(0, 299) != 0);
      end
      rst_n = !((m_ph == S_FAULT && $urandom_range(0, 4) == 0) || $urandom_range(0, 599) == 0);
      tick();
      tests++;
      if (obs_vec() !== exp_vec()) begin
        fails++;
        $display("FAIL random outputs @%0d: got %b, expected %b", c, obs_vec(), exp_vec());
      end
      tests++;
      if (dut.state_q !== m_ph) begin
        fails++;
        $display("FAIL random state @%0d: got %0d, expected %0d", c, dut.state_q, m_ph);
      end
      if (wif.done) done_cnt++;
    end
    rst_n = 1'b1;
    tests++;
    if (done_cnt == 0) begin fails++; $display("FAIL random completions: got 0, expected at least 1"); end
  endtask

  initial begin
    rst_n               = 1'b0;
    wif.start           = 1'b0;
    wif.door_close      = 1'b1;
    wif.filled          = 1'b0;
    wif.detergent_added = 1'b0;
    wif.drained         = 1'b0;
    wif.pause           = 1'b0;
    test_reset();
    test_full_run();
    test_reset_mid();
    test_pause();
    test_collision();
    test_fill_watchdog();
    test_door_open();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL global_timeout: got simulation still running, expected finish");
    $fatal(1, "time limit");
  end

endmodule
